// File: rtl/exec_sequencer.sv
// Run/halt/step controller for the single-cycle MIPS core: gates PC/RegWrite/MemWrite via cycle_en_o.
// Optional runaway-code watchdog compiled in with `define EXEC_WDOG_EN.
module exec_sequencer #(
  parameter int COUNT_W    = 16,
  parameter int WDOG_LIMIT = 1000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               run_i,
  input  logic               halt_i,
  input  logic               step_i,
  input  logic [31:0]        pc_i,
  input  logic [31:0]        bp_addr_i,
  input  logic               bp_enable_i,
  output logic               cycle_en_o,
  output logic [2:0]         state_o,
  output logic               bp_hit_o,
  output logic [COUNT_W-1:0] instr_count_o,
  output logic               wdog_trip_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_HALT  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               run_q, halt_q, step_q;
  logic               bp_skip_q, bp_skip_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               rise_run, rise_halt, rise_step;
  logic               bp_match, cycle_en, wdog_expire;

  assign rise_run  = run_i  & ~run_q;
  assign rise_halt = halt_i & ~halt_q;
  assign rise_step = step_i & ~step_q;

  // bp_skip lets the instruction sitting on the breakpoint commit once after resuming.
  assign bp_match = bp_enable_i & (pc_i == bp_addr_i) & ~bp_skip_q;
  assign cycle_en = ((state_q == S_RUN) & ~bp_match) | (state_q == S_STEP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rise_halt)      state_d = S_HALT;
        else if (rise_step) state_d = S_STEP;
        else if (rise_run)  state_d = S_RUN;
      end
      S_RUN: begin
        if (rise_halt)        state_d = S_HALT;
        else if (bp_match)    state_d = S_BREAK;
        else if (wdog_expire) state_d = S_HALT;
      end
      S_STEP: state_d = S_HALT;
      S_HALT, S_BREAK: begin
        if (rise_step)     state_d = S_STEP;
        else if (rise_run) state_d = S_RUN;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    bp_skip_d = bp_skip_q;
    if ((state_q == S_BREAK) && (state_d == S_RUN)) bp_skip_d = 1'b1;
    else if (state_q == S_RUN)                      bp_skip_d = 1'b0;
  end

  always_comb begin
    count_d = count_q;
    if (cycle_en && (count_q != {COUNT_W{1'b1}})) count_d = count_q + 1'b1;
  end

  // History registers reset to 1 so a button held through reset does not fire.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b1;
      halt_q    <= 1'b1;
      step_q    <= 1'b1;
      bp_skip_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_i;
      halt_q    <= halt_i;
      step_q    <= step_i;
      bp_skip_q <= bp_skip_d;
      count_q   <= count_d;
    end
  end

`ifdef EXEC_WDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT) + 1;

  logic [WD_W-1:0] wd_q, wd_d;
  logic            trip_q, trip_d;

  assign wdog_expire = (state_q == S_RUN) & cycle_en & (wd_q == WD_W'(WDOG_LIMIT - 1));

  always_comb begin
    wd_d = '0;
    if ((state_q == S_RUN) && (state_d == S_RUN)) wd_d = wd_q + 1'b1;
  end

  // Trip only when the watchdog is what ended the run (a Halt edge outranks it).
  always_comb begin
    trip_d = trip_q;
    if (wdog_expire && !rise_halt)
      trip_d = 1'b1;
    else if (((state_d == S_RUN) || (state_d == S_STEP)) && (state_d != state_q))
      trip_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q   <= '0;
      trip_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      trip_q <= trip_d;
    end
  end

  assign wdog_trip_o = trip_q;
`else
  assign wdog_expire = 1'b0;
  assign wdog_trip_o = 1'b0;
`endif

  assign cycle_en_o    = cycle_en;
  assign state_o       = state_q;
  assign bp_hit_o      = (state_q == S_BREAK);
  assign instr_count_o = count_q;

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Run/halt/step controller for the single-cycle MIPS datapath.
- Produces one enable, CycleEn. CycleEn gates PC update, RegisterFile RegWrite and DataMemory MemWrite, so the core runs freely, single-steps, or stops at a PC breakpoint.
- Sits between the board buttons (already debounced) and the PC/RegisterFile/DataMemory write enables.
- Exposes a retired-instruction counter for the TwoDigitDisplay path.

Parameters:
- COUNT_W, 16, width of the retired-instruction counter.
- WDOG_LIMIT, 1000, number of consecutive RUN cycles before a watchdog halt (used only when the optional feature is compiled in).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Run  in  1  level from debounced button; only the rising edge acts.
- Halt  in  1  level from debounced button; only the rising edge acts.
- Step  in  1  level from debounced button; only the rising edge acts.
- PCOut  in  32  current PC value from ProgramCounter.
- BPAddr  in  32  breakpoint byte address.
- BPEnable  in  1  breakpoint compare enable.
- CycleEn  out  1  1 = the current instruction commits this cycle.
- State  out  3  state code: IDLE=0, RUN=1, STEP=2, HALT=3, BREAK=4.
- BPHit  out  1  high while in BREAK.
- InstrCount  out  COUNT_W  count of retired instructions, saturating.
- WdogTrip  out  1  sticky watchdog-halt flag.

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE; InstrCount=0; WdogTrip=0; bp_skip=0; watchdog counter=0.
  - Edge-detect history registers load 1, so a button held through reset does not fire.
  - Outputs during reset: CycleEn=0, BPHit=0, State=0.
- Edge detect: rRun = Run & ~Run_q (same for Halt, Step); one cycle latency from input to action.
- Event priority when several edges land in the same cycle: Halt > Step > Run.
- bp_match = BPEnable & (PCOut == BPAddr) & ~bp_skip.
- CycleEn is combinational: (state==RUN & ~bp_match) | (state==STEP). The instruction at a breakpoint is never committed in RUN.
- Transitions, evaluated at each rising edge:
  - IDLE: rHalt -> HALT; rStep -> STEP; rRun -> RUN; otherwise stay.
  - RUN: rHalt -> HALT; bp_match -> BREAK; watchdog expiry -> HALT (feature only); rStep ignored; otherwise stay.
  - STEP: always -> HALT after exactly one CycleEn cycle. Edges arriving during STEP are dropped. The breakpoint is ignored in STEP.
  - HALT: rStep -> STEP; rRun -> RUN; rHalt has no effect.
  - BREAK: rStep -> STEP; rRun -> RUN with bp_skip set.
- bp_skip:
  - Set on the BREAK->RUN transition.
  - Cleared after the first RUN cycle, so the breakpointed instruction executes once.
  - A loop that returns to BPAddr re-breaks.
- InstrCount: +1 on every rising edge where CycleEn=1; holds at all-ones (no wrap).
- BPEnable dropped while in BREAK: the state stays BREAK until a Run or Step edge.
- Undefined state codes recover to HALT on the next edge.
- BPHit = (state==BREAK), registered through the state register.

Optional Feature:
- Macro: EXEC_WDOG_EN.
- Defined:
  - A counter of consecutive cycles in RUN, cleared on any exit from RUN.
  - When it reaches WDOG_LIMIT-1 with CycleEn=1, the next state is HALT and WdogTrip is set.
  - WdogTrip stays high until the next entry into RUN or STEP, where it clears.
  - This catches runaway code such as jumping off the end of InstructionMemory.
- Not defined: no counter is built, WdogTrip is tied 0, and RUN continues indefinitely.

Test Plan:
- Hold Reset=0 with Run=1, release, hold Run high 10 cycles -> State=0, CycleEn=0, InstrCount=0 throughout (no false edge).
- Pulse Run -> State=1 next cycle; after 20 cycles InstrCount=20. Pulse Halt -> State=3, CycleEn=0, InstrCount frozen at its value.
- From HALT, three Step pulses spaced 4 cycles apart -> three single-cycle CycleEn pulses, State sequence 2->3 each time, InstrCount +3.
- BPEnable=1, BPAddr=0x10, Run from PC=0 -> CycleEn drops when PCOut=0x10, State=4, BPHit=1, InstrCount=4. Pulse Run -> the 0x10 instruction commits (InstrCount=5) and execution continues.
- Halt and Run rising in the same cycle from IDLE -> HALT. Step and Run rising together from HALT -> STEP.
- With EXEC_WDOG_EN and WDOG_LIMIT=8: Run -> after 8 CycleEn cycles State=3, WdogTrip=1. A Step pulse clears WdogTrip. Without the macro: RUN persists, WdogTrip=0.
